// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 read/write engines.
// Timing defaults assume a 50 MHz CLK.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        RECOVER
    } lcd_rd_state_t;

    localparam logic RS_INSTR   = 1'b0;
    localparam logic RS_DATA    = 1'b1;
    localparam int   LCD_BF_BIT = 7;

    localparam int LCD_T_AS_CYC    = 3;
    localparam int LCD_T_PW_CYC    = 25;
    localparam int LCD_T_H_CYC     = 2;
    localparam int LCD_T_CYCLE_CYC = 50;
    localparam int LCD_POLL_MAX    = 2000;

    // Recovery time pads the bus cycle out to the E-rise-to-E-rise minimum.
    function automatic int lcd_t_rec(input int cyc, input int as_c, input int pw, input int h);
        int r;
        r = cyc - as_c - pw - h;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Host-side handshake between a requester and the LCD read engine.
interface lcd_reader_if;
    logic       req;
    logic       rs;
    logic       poll;
    logic       ready;
    logic       bus_busy;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       timeout;

    modport master (
        output req, rs, poll,
        input  ready, bus_busy, rd_valid, rd_data, timeout
    );

    modport slave (
        input  req, rs, poll,
        output ready, bus_busy, rd_valid, rd_data, timeout
    );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded phase.
module lcd_phase_timer #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/lcd_reader.sv
// Read-side engine for an 8-bit HD44780 bus: single BF/AC or data reads,
// plus optional busy-flag polling until BF clears or the poll limit is hit.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS_CYC    = LCD_T_AS_CYC,
    parameter int T_PW_CYC    = LCD_T_PW_CYC,
    parameter int T_H_CYC     = LCD_T_H_CYC,
    parameter int T_CYCLE_CYC = LCD_T_CYCLE_CYC,
    parameter int POLL_MAX    = LCD_POLL_MAX
) (
    input  logic              CLK,
    input  logic              RESET,
    lcd_reader_if.slave       bus,
    input  logic [7:0]        LCD_D_IN,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic              LCD_E
);

    localparam int TW    = $clog2(T_CYCLE_CYC + 1);
    localparam int PCW   = $clog2(POLL_MAX + 1);
    localparam int T_REC = lcd_t_rec(T_CYCLE_CYC, T_AS_CYC, T_PW_CYC, T_H_CYC);

    localparam logic [TW-1:0]  L_AS   = TW'(T_AS_CYC);
    localparam logic [TW-1:0]  L_PW   = TW'(T_PW_CYC);
    localparam logic [TW-1:0]  L_H    = TW'(T_H_CYC);
    localparam logic [TW-1:0]  L_REC  = TW'(T_REC);
    localparam logic [PCW-1:0] P_LIM  = PCW'(POLL_MAX);

    lcd_rd_state_t  state, state_nxt;
    logic           tmr_ld, tmr_done;
    logic [TW-1:0]  tmr_val;
    logic           poll_q;
    logic [PCW-1:0] poll_cnt;
    logic [7:0]     rd_data_q;
    logic           rd_valid_q, timeout_q;
    logic           accept, sample, finish;

    lcd_phase_timer #(.W(TW)) u_tmr (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (tmr_ld),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        tmr_ld    = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        sample    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (bus.req) begin
                accept    = 1'b1;
                state_nxt = SETUP;
                tmr_ld    = 1'b1;
                tmr_val   = L_AS;
            end
            SETUP: if (tmr_done) begin
                state_nxt = E_HIGH;
                tmr_ld    = 1'b1;
                tmr_val   = L_PW;
            end
            E_HIGH: if (tmr_done) begin
                sample    = 1'b1;
                state_nxt = HOLD;
                tmr_ld    = 1'b1;
                tmr_val   = L_H;
            end
            HOLD: if (tmr_done) begin
                state_nxt = RECOVER;
                tmr_ld    = 1'b1;
                tmr_val   = L_REC;
            end
            RECOVER: if (tmr_done) begin
                // Counter is checked here, so it never passes POLL_MAX.
                if (poll_q && rd_data_q[LCD_BF_BIT] && (poll_cnt < P_LIM)) begin
                    state_nxt = SETUP;
                    tmr_ld    = 1'b1;
                    tmr_val   = L_AS;
                end else begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            poll_q     <= 1'b0;
            poll_cnt   <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_RW     <= 1'b0;
            LCD_E      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_valid_q <= finish;
            timeout_q  <= finish & poll_q & rd_data_q[LCD_BF_BIT];
            // Pins follow the next state so they change cleanly on the edge.
            LCD_E      <= (state_nxt == E_HIGH);
            LCD_RW     <= (state_nxt != IDLE);
            if (accept) begin
                LCD_RS   <= bus.rs;
                poll_q   <= bus.poll & (bus.rs == RS_INSTR);
                poll_cnt <= '0;
            end
            if (sample) begin
                rd_data_q <= LCD_D_IN;
                poll_cnt  <= poll_cnt + 1'b1;
            end
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.bus_busy = (state != IDLE);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: default instance plus a POLL_MAX=4 instance.
module tb_lcd_reader;
    import lcd_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] din = 8'h00;
    logic       LCD_RS, LCD_RW, LCD_E;
    logic       LCD_RS4, LCD_RW4, LCD_E4;

    lcd_reader_if bus ();
    lcd_reader_if bus4 ();

    lcd_reader dut (
        .CLK(CLK), .RESET(RESET), .bus(bus), .LCD_D_IN(din),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E)
    );

    lcd_reader #(.POLL_MAX(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .bus(bus4), .LCD_D_IN(din),
        .LCD_RS(LCD_RS4), .LCD_RW(LCD_RW4), .LCD_E(LCD_E4)
    );

    always #10 CLK = ~CLK;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Observation mux selecting which instance the monitor watches.
    bit         msel = 1'b0;
    logic       s_e, s_rw, s_rs, s_vld, s_to, s_rdy;
    logic [7:0] s_rd;
    always_comb begin
        s_e   = msel ? LCD_E4        : LCD_E;
        s_rw  = msel ? LCD_RW4       : LCD_RW;
        s_rs  = msel ? LCD_RS4       : LCD_RS;
        s_vld = msel ? bus4.rd_valid : bus.rd_valid;
        s_to  = msel ? bus4.timeout  : bus.timeout;
        s_rdy = msel ? bus4.ready    : bus.ready;
        s_rd  = msel ? bus4.rd_data  : bus.rd_data;
    end

    int rises[$];
    int rise_cnt, eh_cnt, vld_cnt, vld_at, to_cnt, to_at, rs_bad, rw_pre, rdy_bad;

    function automatic int rise(input int i);
        return (i < rises.size()) ? rises[i] : -1;
    endfunction

    task automatic set_req(input bit sel4, input logic v);
        if (sel4) bus4.req = v;
        else      bus.req  = v;
    endtask

    // Runs ncyc edges; k=0 is the first edge (the acceptance edge when req is set beforehand).
    task automatic run(input bit sel4, input int ncyc, input int req_off, input logic exp_rs,
                       input int d_sw, input logic [7:0] d2, input int pulse_at);
        bit prev_e;
        prev_e = 1'b0;
        msel = sel4;
        rises.delete();
        rise_cnt = 0; eh_cnt = 0; vld_cnt = 0; vld_at = -1; to_cnt = 0; to_at = -1;
        rs_bad = 0; rw_pre = 0; rdy_bad = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge CLK); #1;
            if (s_e && !prev_e) begin
                rise_cnt++;
                rises.push_back(k);
                if (rise_cnt == d_sw) din = d2;
            end
            prev_e = s_e;
            if (s_e) eh_cnt++;
            if (s_rw && !s_e && rise_cnt == 0) rw_pre++;
            if (s_rw && s_rs !== exp_rs) rs_bad++;
            if (s_vld) begin
                vld_cnt++;
                if (vld_at < 0) vld_at = k;
                if (!s_rdy) rdy_bad++;
            end
            if (s_to) begin
                to_cnt++;
                if (to_at < 0) to_at = k;
            end
            if (k == req_off) set_req(sel4, 1'b0);
            if (k == pulse_at) begin
                bus.req = 1'b1;
                bus.rs  = ~exp_rs;
            end
            if (k == pulse_at + 1) bus.req = 1'b0;
        end
    endtask

    int quiet_vld;

    initial begin
        bus.req = 1'b0;  bus.rs = 1'b0;  bus.poll = 1'b0;
        bus4.req = 1'b0; bus4.rs = 1'b0; bus4.poll = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_e", LCD_E, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.bus_busy, 0);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_ready", bus.ready, 1);

        // Single data read
        din = 8'hA5; bus.rs = RS_DATA; bus.poll = 1'b0; bus.req = 1'b1;
        run(0, 55, 0, 1'b1, 99, 8'h00, -10);
        chk("rd_setup_cycles", rw_pre, 3);
        chk("rd_rs_stable", rs_bad, 0);
        chk("rd_first_rise", rise(0), 3);
        chk("rd_e_width", eh_cnt, 25);
        chk("rd_valid_at", vld_at, 50);
        chk("rd_valid_cnt", vld_cnt, 1);
        chk("rd_data", bus.rd_data, 8'hA5);
        chk("rd_timeout", to_cnt, 0);
        chk("rd_ready_at_valid", rdy_bad, 0);

        // Busy poll clearing on the fourth read
        din = 8'h85; bus.rs = RS_INSTR; bus.poll = 1'b1; bus.req = 1'b1;
        run(0, 210, 0, 1'b0, 4, 8'h05, -10);
        bus.poll = 1'b0;
        chk("poll_rises", rise_cnt, 4);
        chk("poll_rise_gap", rise(1) - rise(0), 50);
        chk("poll_rise_span", rise(3) - rise(0), 150);
        chk("poll_valid_at", vld_at, 200);
        chk("poll_valid_cnt", vld_cnt, 1);
        chk("poll_rd_data", bus.rd_data, 8'h05);
        chk("poll_timeout", to_cnt, 0);

        // Poll limit reached with BF stuck high (POLL_MAX=4 instance)
        din = 8'h80; bus4.rs = RS_INSTR; bus4.poll = 1'b1; bus4.req = 1'b1;
        run(1, 210, 0, 1'b0, 99, 8'h00, -10);
        chk("lim_rises", rise_cnt, 4);
        chk("lim_valid_at", vld_at, 200);
        chk("lim_timeout_at", to_at, 200);
        chk("lim_timeout_cnt", to_cnt, 1);
        chk("lim_rd_data", bus4.rd_data, 8'h80);

        // Reset on the tenth E_HIGH cycle
        din = 8'h3C; bus.rs = RS_DATA; bus.req = 1'b1;
        run(0, 13, 0, 1'b1, 99, 8'h00, -10);
        chk("mid_e_before", LCD_E, 1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_e", LCD_E, 0);
        chk("mid_rst_rw", LCD_RW, 0);
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_valid", bus.rd_valid, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        quiet_vld = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK); #1;
            if (bus.rd_valid) quiet_vld++;
        end
        chk("mid_no_valid", quiet_vld, 0);
        bus.req = 1'b1;
        run(0, 55, 0, 1'b1, 99, 8'h00, -10);
        chk("mid_retry_valid_at", vld_at, 50);
        chk("mid_retry_data", bus.rd_data, 8'h3C);

        // req held high: back-to-back reads accepted in the rd_valid cycle
        din = 8'h5A; bus.rs = RS_DATA; bus.req = 1'b1;
        run(0, 210, 160, 1'b1, 99, 8'h00, -10);
        chk("b2b_rises", rise_cnt, 4);
        chk("b2b_gap1", rise(1) - rise(0), 51);
        chk("b2b_gap2", rise(2) - rise(1), 51);
        chk("b2b_valid_cnt", vld_cnt, 4);
        chk("b2b_first_valid", vld_at, 50);
        chk("b2b_ready_at_valid", rdy_bad, 0);

        // req pulse and rs change while busy are ignored
        din = 8'hC3; bus.rs = RS_DATA; bus.req = 1'b1;
        run(0, 70, 0, 1'b1, 99, 8'h00, 10);
        chk("busy_req_valid_cnt", vld_cnt, 1);
        chk("busy_req_rises", rise_cnt, 1);
        chk("busy_rs_stable", rs_bad, 0);
        chk("busy_rd_data", bus.rd_data, 8'hC3);
        chk("busy_idle_after", bus.bus_busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
